// File: rtl/imem_load_ctrl.sv
// Instruction-memory sequencer: clears all DEPTH words after reset, then streams program words into the write port.
// Write is combinational from load_valid in LOAD; load_ready is high for the whole LOAD state, so bubbles simply stall idx.
module imem_load_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic [AW-1:0] load_base,
  input  logic [AW:0]   load_count,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_stall,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic [AW:0]   r_idx;
  logic [AW-1:0] r_base;
  logic [AW:0]   r_count;
  logic          r_done;
  logic          r_err;

  logic          w_cnt_legal;
  logic          w_start_ok;
  logic          w_start_bad;
  logic          w_xfer;
  logic          w_last;
  logic          w_clear_last;
  logic [AW:0]   w_sum;
  logic [AW-1:0] w_load_addr;

  assign w_cnt_legal  = (load_count != '0) && (load_count <= DEPTH_W);
  assign w_start_ok   = (r_state == S_IDLE) && load_start && w_cnt_legal;
  assign w_start_bad  = (r_state == S_IDLE) && load_start && !w_cnt_legal;
  assign w_xfer       = (r_state == S_LOAD) && load_valid;
  assign w_last       = w_xfer && (r_idx == r_count - 1'b1);
  assign w_clear_last = (r_state == S_CLEAR) && (r_idx == DEPTH_W - 1'b1);

  // Address wraps modulo DEPTH, which need not be a power of two.
  assign w_sum       = {1'b0, r_base} + r_idx;
  assign w_load_addr = (w_sum >= DEPTH_W) ? AW'(w_sum - DEPTH_W) : w_sum[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_CLEAR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: if (w_clear_last) w_next = S_IDLE;
      S_IDLE:  if (w_start_ok)   w_next = S_LOAD;
      S_LOAD:  if (w_last)       w_next = S_IDLE;
      default:                   w_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_base  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start_bad) r_err <= 1'b1;
      case (r_state)
        S_CLEAR: r_idx <= w_clear_last ? '0 : r_idx + 1'b1;
        S_IDLE: begin
          if (w_start_ok) begin
            r_base  <= load_base;
            r_count <= load_count;
            r_idx   <= '0;
          end
        end
        S_LOAD:  if (w_xfer) r_idx <= r_idx + 1'b1;
        default: r_idx <= '0;
      endcase
    end
  end

  // Reset gates the outputs directly so a write in flight is dropped the moment reset rises.
  always_comb begin
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    cpu_stall  = 1'b1;
    busy       = 1'b1;
    if (!reset) begin
      case (r_state)
        S_CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = r_idx[AW-1:0];
        end
        S_IDLE: begin
          cpu_stall = 1'b0;
          busy      = 1'b0;
        end
        S_LOAD: begin
          load_ready = 1'b1;
          mem_we     = load_valid;
          mem_waddr  = w_load_addr;
          mem_wdata  = load_data;
        end
        default: ;
      endcase
    end
  end

  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized scoreboard bench for imem_load_ctrl: expected writes are queued at issue time, a negedge monitor pops them.
module tb_imem_load_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW:0]   load_count = '0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready, mem_we, cpu_stall, busy, done, err;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_base(load_base),
    .load_count(load_count), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .cpu_stall(cpu_stall), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_done = 0;
  int act_done = 0;
  logic exp_err = 1'b0;
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0] words[0:DEPTH-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", mem_waddr, mem_wdata);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          if ({mem_waddr, mem_wdata} !== e) begin
            n_fail++;
            $display("FAIL write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                     mem_waddr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
      end
      if (done) act_done++;
    end
  end

  task automatic do_reset();
    int n;
    reset = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_stall", cpu_stall, 1);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), {DW{1'b0}}});
    reset = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      load_start = (n == 10);
      load_count = '0;
      @(posedge clk);
      #1;
      n++;
    end
    load_start = 1'b0;
    chk("clear_cycles", n, DEPTH);
    chk("clear_queue_drained", exp_q.size(), 0);
    chk("post_clear_stall", cpu_stall, 0);
    chk("start_in_clear_ignored_err", err, 0);
  endtask

  task automatic fill_rand(input int cnt);
    for (int i = 0; i < cnt; i++) words[i] = $urandom;
  endtask

  // Issues a load; vpat selects fixed valid pattern, abort_at asserts reset while that word is presented.
  task automatic do_load(input int base, input int cnt, input int use_pat,
                         input logic [15:0] vpat, input int abort_at);
    int i, c;
    logic v;
    load_start = 1'b1;
    load_base  = AW'(base);
    load_count = (AW+1)'(cnt);
    for (int k = 0; k < cnt; k++) exp_q.push_back({AW'((base + k) % DEPTH), words[k]});
    @(posedge clk);
    #1;
    load_start = 1'b0;
    chk("load_stall", cpu_stall, 1);
    chk("load_ready", load_ready, 1);
    i = 0;
    c = 0;
    while (i < cnt && c < 1000) begin
      v = use_pat ? ((c < 16) ? vpat[c] : 1'b1) : ($urandom_range(0, 3) != 0);
      load_valid = v;
      load_data  = v ? words[i] : $urandom;
      load_start = ($urandom_range(0, 7) == 0);
      load_count = '0;
      if (i == abort_at && v) begin
        reset = 1'b1;
        #1;
        chk("abort_mem_we", mem_we, 0);
        chk("abort_ready", load_ready, 0);
        load_valid = 1'b0;
        load_start = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (v) i++;
      c++;
      if (i < cnt) chk("done_early", done, 0);
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    chk("load_bounded", c < 1000, 1);
    exp_done++;
    chk("done_pulse", done, 1);
    chk("end_stall", cpu_stall, 0);
    chk("end_busy", busy, 0);
    chk("err_after_load", err, exp_err);
  endtask

  task automatic bad_start(input int cnt);
    load_start = 1'b1;
    load_count = (AW+1)'(cnt);
    @(posedge clk);
    #1;
    load_start = 1'b0;
    exp_err = 1'b1;
    chk("bad_err", err, 1);
    chk("bad_stays_idle", busy, 0);
    @(posedge clk);
    #1;
    chk("bad_no_done", done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    words[0] = 32'h0031_0093;
    words[1] = 32'h0093_8333;
    words[2] = 32'h02E1_2223;
    do_load(1, 3, 1, 16'hFFFF, -1);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);

    fill_rand(4);
    do_load(62, 4, 1, 16'hFFFF, -1);

    fill_rand(2);
    do_load(20, 2, 1, 16'b1001, -1);

    bad_start(0);
    bad_start(65);
    fill_rand(1);
    do_load(7, 1, 1, 16'hFFFF, -1);
    chk("err_sticky", err, 1);

    // Back-to-back loads: each new start lands in the done cycle of the previous one.
    for (int t = 0; t < 20; t++) begin
      int cnt;
      cnt = (t == 5) ? DEPTH : $urandom_range(1, DEPTH);
      fill_rand(cnt);
      do_load($urandom_range(0, DEPTH - 1), cnt, 0, 16'h0, -1);
    end

    fill_rand(5);
    do_load(40, 5, 1, 16'hFFFF, 1);
    do_reset();
    @(posedge clk); #1;
    chk("no_done_after_abort", done, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", act_done, exp_done);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
